// File: rtl/ili9341_par8_driver.sv
// ILI9341 8080-style 8-bit parallel bus driver: power-on reset, init ROM walk,
// address-window re-send and RGB565 pixel writes as two data bytes each.
module ili9341_par8_driver #(
    parameter int unsigned RESET_LOW_CYCLES  = 160,
    parameter int unsigned RESET_WAIT_CYCLES = 1_920_000,
    parameter int unsigned SLEEP_WAIT_CYCLES = 1_920_000
) (
    input  logic        clk_16MHz,
    input  logic        resetn,
    input  logic        reset_cursor,
    input  logic [15:0] pix_data,
    input  logic        pix_clk,
    output logic        busy,
    output logic        nreset,
    output logic        cmd_data,
    output logic        write_edge,
    output logic [7:0]  dout
);

    typedef enum logic [2:0] {
        RST_LOW, RST_WAIT, INIT_A, SLEEP_WAIT, INIT_B, CURSOR, IDLE, PIXEL
    } state_t;

    localparam logic [20:0] RST_LOW_LAST   = 21'(RESET_LOW_CYCLES - 1);
    localparam logic [20:0] RST_WAIT_LAST  = 21'(RESET_WAIT_CYCLES - 1);
    localparam logic [20:0] SLEEP_LAST     = 21'(SLEEP_WAIT_CYCLES - 1);
    localparam logic [4:0]  INIT_B_FIRST   = 5'd1;
    localparam logic [4:0]  INIT_B_LAST    = 5'd5;
    localparam logic [4:0]  CURSOR_FIRST   = 5'd6;
    localparam logic [4:0]  CURSOR_LAST    = 5'd16;

    // Init ROM entries are {dc, byte}; index ranges select INIT_A, INIT_B, CURSOR.
    function automatic logic [8:0] rom_entry(input logic [4:0] i);
        case (i)
            5'd0:    rom_entry = 9'h011;
            5'd1:    rom_entry = 9'h03A;
            5'd2:    rom_entry = 9'h155;
            5'd3:    rom_entry = 9'h036;
            5'd4:    rom_entry = 9'h128;
            5'd5:    rom_entry = 9'h029;
            5'd6:    rom_entry = 9'h02A;
            5'd7:    rom_entry = 9'h100;
            5'd8:    rom_entry = 9'h100;
            5'd9:    rom_entry = 9'h101;
            5'd10:   rom_entry = 9'h13F;
            5'd11:   rom_entry = 9'h02B;
            5'd12:   rom_entry = 9'h100;
            5'd13:   rom_entry = 9'h100;
            5'd14:   rom_entry = 9'h100;
            5'd15:   rom_entry = 9'h1EF;
            5'd16:   rom_entry = 9'h02C;
            default: rom_entry = 9'h000;
        endcase
    endfunction

    state_t      state_reg, state_next;
    logic        phase_reg, phase_next;
    logic [4:0]  idx_reg, idx_next;
    logic [20:0] cnt_reg, cnt_next;
    logic [15:0] hold_reg, hold_next;
    logic        pend_cursor_reg, pend_cursor_next;
    logic        pend_pixel_reg, pend_pixel_next;
    logic        nreset_reg, nreset_next;
    logic        busy_reg, busy_next;
    logic        we_reg, we_next;
    logic        dc_reg, dc_next;
    logic [7:0]  dout_reg, dout_next;

    logic        emit;
    logic [8:0]  emit_word;
    logic        seq_done;
    logic [4:0]  last_idx;

    always_comb begin
        state_next       = state_reg;
        phase_next       = phase_reg;
        idx_next         = idx_reg;
        cnt_next         = cnt_reg;
        hold_next        = hold_reg;
        pend_cursor_next = pend_cursor_reg;
        pend_pixel_next  = pend_pixel_reg;
        nreset_next      = nreset_reg;
        busy_next        = busy_reg;
        we_next          = we_reg;
        dc_next          = dc_reg;
        dout_next        = dout_reg;
        emit             = 1'b0;
        emit_word        = 9'h000;
        seq_done         = 1'b0;

        case (state_reg)
            INIT_A:  last_idx = 5'd0;
            INIT_B:  last_idx = INIT_B_LAST;
            CURSOR:  last_idx = CURSOR_LAST;
            default: last_idx = 5'd1;
        endcase

        if (reset_cursor && (state_reg inside {INIT_A, SLEEP_WAIT, INIT_B, CURSOR, PIXEL}))
            pend_cursor_next = 1'b1;

        case (state_reg)
            RST_LOW: begin
                if (cnt_reg == RST_LOW_LAST) begin
                    state_next  = RST_WAIT;
                    cnt_next    = '0;
                    nreset_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 21'd1;
                end
            end
            RST_WAIT: begin
                if (cnt_reg == RST_WAIT_LAST) begin
                    state_next = INIT_A;
                    idx_next   = 5'd0;
                    phase_next = 1'b0;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 21'd1;
                end
            end
            SLEEP_WAIT: begin
                if (cnt_reg == SLEEP_LAST) begin
                    state_next = INIT_B;
                    idx_next   = INIT_B_FIRST;
                    phase_next = 1'b0;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 21'd1;
                end
            end
            IDLE: begin
                // busy is still high for the first IDLE cycle after a sequence
                busy_next = 1'b0;
                if (reset_cursor || pend_cursor_reg) begin
                    state_next       = CURSOR;
                    idx_next         = CURSOR_FIRST;
                    emit             = 1'b1;
                    emit_word        = rom_entry(CURSOR_FIRST);
                    busy_next        = 1'b1;
                    pend_cursor_next = 1'b0;
                    if (pix_clk && !busy_reg) begin
                        pend_pixel_next = 1'b1;
                        hold_next       = pix_data;
                    end
                end else if (pix_clk && !busy_reg) begin
                    state_next = PIXEL;
                    idx_next   = 5'd0;
                    hold_next  = pix_data;
                    emit       = 1'b1;
                    emit_word  = {1'b1, pix_data[15:8]};
                    busy_next  = 1'b1;
                end
            end
            default: begin
                if (!phase_reg) begin
                    emit      = 1'b1;
                    emit_word = (state_reg == PIXEL)
                              ? {1'b1, (idx_reg[0] ? hold_reg[7:0] : hold_reg[15:8])}
                              : rom_entry(idx_reg);
                end else begin
                    we_next    = 1'b1;
                    phase_next = 1'b0;
                    if (idx_reg == last_idx)
                        seq_done = 1'b1;
                    else
                        idx_next = idx_reg + 5'd1;
                end
            end
        endcase

        // Chaining straight into the next sequence keeps the bus gap-free.
        if (seq_done) begin
            case (state_reg)
                INIT_A: begin
                    state_next = SLEEP_WAIT;
                    cnt_next   = '0;
                end
                INIT_B: begin
                    state_next       = CURSOR;
                    idx_next         = CURSOR_FIRST;
                    pend_cursor_next = 1'b0;
                end
                default: begin
                    if (pend_cursor_next) begin
                        state_next       = CURSOR;
                        idx_next         = CURSOR_FIRST;
                        pend_cursor_next = 1'b0;
                    end else if (pend_pixel_reg) begin
                        state_next      = PIXEL;
                        idx_next        = 5'd0;
                        pend_pixel_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            endcase
        end

        if (emit) begin
            dout_next  = emit_word[7:0];
            dc_next    = emit_word[8];
            we_next    = 1'b0;
            phase_next = 1'b1;
        end
    end

    always_ff @(posedge clk_16MHz) begin
        if (!resetn) begin
            state_reg       <= RST_LOW;
            phase_reg       <= 1'b0;
            idx_reg         <= '0;
            cnt_reg         <= '0;
            hold_reg        <= '0;
            pend_cursor_reg <= 1'b0;
            pend_pixel_reg  <= 1'b0;
            nreset_reg      <= 1'b0;
            busy_reg        <= 1'b1;
            we_reg          <= 1'b1;
            dc_reg          <= 1'b1;
            dout_reg        <= 8'h00;
        end else begin
            state_reg       <= state_next;
            phase_reg       <= phase_next;
            idx_reg         <= idx_next;
            cnt_reg         <= cnt_next;
            hold_reg        <= hold_next;
            pend_cursor_reg <= pend_cursor_next;
            pend_pixel_reg  <= pend_pixel_next;
            nreset_reg      <= nreset_next;
            busy_reg        <= busy_next;
            we_reg          <= we_next;
            dc_reg          <= dc_next;
            dout_reg        <= dout_next;
        end
    end

    assign busy       = busy_reg;
    assign nreset     = nreset_reg;
    assign cmd_data   = dc_reg;
    assign write_edge = we_reg;
    assign dout       = dout_reg;

endmodule

// File: tb/tb_ili9341_par8_driver.sv
// Directed bench for ili9341_par8_driver: init sequence, pixel writes,
// strobes while busy, simultaneous/pending cursor requests and mid-byte reset.
module tb_ili9341_par8_driver;

    logic        clk = 1'b0;
    logic        resetn;
    logic        reset_cursor;
    logic [15:0] pix_data;
    logic        pix_clk;
    logic        busy, nreset, cmd_data, write_edge;
    logic [7:0]  dout;

    always #5 clk = ~clk;

    ili9341_par8_driver #(
        .RESET_LOW_CYCLES (4),
        .RESET_WAIT_CYCLES(8),
        .SLEEP_WAIT_CYCLES(8)
    ) dut (
        .clk_16MHz   (clk),
        .resetn      (resetn),
        .reset_cursor(reset_cursor),
        .pix_data    (pix_data),
        .pix_clk     (pix_clk),
        .busy        (busy),
        .nreset      (nreset),
        .cmd_data    (cmd_data),
        .write_edge  (write_edge),
        .dout        (dout)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] exp_init [17] = '{
        9'h011, 9'h03A, 9'h155, 9'h036, 9'h128, 9'h029,
        9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F,
        9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C
    };

    logic [8:0] edge_q [$];
    logic [8:0] expq   [$];
    logic       we_prev  = 1'b1;
    logic       seen_bad = 1'b0;

    // Record {dc, byte} at every WRX rising edge seen while the panel is out of reset.
    always @(negedge clk) begin
        if (nreset === 1'b1 && we_prev === 1'b0 && write_edge === 1'b1)
            edge_q.push_back({cmd_data, dout});
        if (dout === 8'h12 || dout === 8'h34)
            seen_bad = 1'b1;
        we_prev = write_edge;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag);
        logic [8:0] got;
        check({tag, "_count"}, 32'(edge_q.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            got = (i < edge_q.size()) ? edge_q[i] : 9'h1FF;
            check($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(expq[i]));
        end
    endtask

    task automatic push_cursor();
        for (int i = 6; i < 17; i++) expq.push_back(exp_init[i]);
    endtask

    task automatic check_reset();
        check("rst_nreset", 32'(nreset), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_write_edge", 32'(write_edge), 32'd1);
        check("rst_cmd_data", 32'(cmd_data), 32'd1);
        check("rst_dout", 32'(dout), 32'h00);
    endtask

    // Called at the negedge where resetn is released; returns at the first busy-low sample.
    task automatic init_check();
        int n_low;
        int n_busy;
        edge_q.delete();
        n_low  = 0;
        n_busy = 0;
        for (int i = 0; i < 300; i++) begin
            if (nreset === 1'b0) n_low++;
            if (busy === 1'b0) break;
            n_busy++;
            @(negedge clk);
        end
        check("nreset_low_cycles", 32'(n_low), 32'd4);
        check("init_busy_cycles", 32'(n_busy), 32'd55);
        expq.delete();
        for (int i = 0; i < 17; i++) expq.push_back(exp_init[i]);
        check_q("init");
    endtask

    int nb;

    initial begin
        resetn       = 1'b0;
        reset_cursor = 1'b0;
        pix_clk      = 1'b0;
        pix_data     = 16'h0000;

        // Power-on
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        resetn = 1'b1;
        init_check();
        $display("power-on: init sequence done, busy low");

        // Pixel write 0xF81F
        @(negedge clk); edge_q.delete(); pix_clk = 1'b1; pix_data = 16'hF81F;
        @(negedge clk); pix_clk = 1'b0;
        check("pix_t1_busy", 32'(busy), 32'd1);
        check("pix_t1_dout", 32'(dout), 32'hF8);
        check("pix_t1_dc", 32'(cmd_data), 32'd1);
        check("pix_t1_we", 32'(write_edge), 32'd0);
        @(negedge clk);
        check("pix_t2_we", 32'(write_edge), 32'd1);
        check("pix_t2_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("pix_t3_dout", 32'(dout), 32'h1F);
        check("pix_t3_we", 32'(write_edge), 32'd0);
        check("pix_t3_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("pix_t4_we", 32'(write_edge), 32'd1);
        check("pix_t4_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("pix_t5_busy", 32'(busy), 32'd0);
        expq.delete(); expq.push_back(9'h1F8); expq.push_back(9'h11F);
        check_q("pix");
        $display("pixel 0xF81F: bytes F8,1F");

        // Strobe while busy: 0x1234 at t+2 must be dropped
        @(negedge clk); edge_q.delete(); seen_bad = 1'b0; pix_clk = 1'b1; pix_data = 16'h5AA5;
        @(negedge clk); pix_clk = 1'b0;
        @(negedge clk); pix_clk = 1'b1; pix_data = 16'h1234;
        @(negedge clk); pix_clk = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_strobe_busy", 32'(busy), 32'd0);
        check("busy_strobe_no_12_34", 32'(seen_bad), 32'd0);
        expq.delete(); expq.push_back(9'h15A); expq.push_back(9'h1A5);
        check_q("busy_strobe");
        $display("pixel 0x5AA5 with 0x1234 strobe while busy: dropped");

        // Simultaneous reset_cursor and pix_clk
        @(negedge clk); edge_q.delete(); reset_cursor = 1'b1; pix_clk = 1'b1; pix_data = 16'hABCD;
        @(negedge clk); reset_cursor = 1'b0; pix_clk = 1'b0;
        nb = 0;
        for (int i = 0; i < 60 && busy === 1'b1; i++) begin
            nb++;
            @(negedge clk);
        end
        check("simul_busy_cycles", 32'(nb), 32'd26);
        expq.delete(); push_cursor(); expq.push_back(9'h1AB); expq.push_back(9'h1CD);
        check_q("simul");
        $display("simultaneous strobes: cursor then AB,CD, busy %0d cycles", nb);

        // Cursor request at t+3 of a pixel write
        @(negedge clk); edge_q.delete(); pix_clk = 1'b1; pix_data = 16'h0F0F;
        nb = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            pix_clk      = 1'b0;
            reset_cursor = (i == 3);
            if (busy === 1'b1) nb++;
        end
        @(negedge clk); reset_cursor = 1'b0;
        for (int i = 0; i < 60 && busy === 1'b1; i++) begin
            nb++;
            @(negedge clk);
        end
        check("pend_busy_cycles", 32'(nb), 32'd26);
        expq.delete(); expq.push_back(9'h10F); expq.push_back(9'h10F); push_cursor();
        check_q("pend");
        $display("pending cursor: pixel 0F,0F then cursor, busy %0d cycles", nb);

        // Reset in the middle of a byte
        @(negedge clk); pix_clk = 1'b1; pix_data = 16'hC3C3;
        @(negedge clk); pix_clk = 1'b0;
        check("midrst_pre_we", 32'(write_edge), 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        check_reset();
        resetn = 1'b1;
        init_check();
        $display("reset mid-byte: init sequence repeated");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ili9341_par8_driver.md
# ili9341_par8_driver

Byte-level driver for the ILI9341 LCD on its 8-bit 8080-style parallel bus. It sits directly downstream of the TIA video stage. It runs the power-on reset and initialisation sequence, then accepts 16-bit RGB565 pixels through a single-pulse strobe and shifts each one out as two bus writes. On request it re-issues the column/page window so the next pixel lands at (0,0).

## Interface
Parameters:
- RESET_LOW_CYCLES, default 160: cycles `nreset` is held low (10 µs at 16 MHz).
- RESET_WAIT_CYCLES, default 1_920_000: wait after `nreset` release, before the first command (120 ms).
- SLEEP_WAIT_CYCLES, default 1_920_000: wait after Sleep Out (0x11).

Ports:
- clk_16MHz, input, 1: sole clock. All logic is on the rising edge.
- resetn, input, 1: **synchronous, active-low** reset.
- reset_cursor, input, 1: one-cycle pulse. Re-sends the address window and Memory Write.
- pix_data, input, 16: RGB565 pixel. Sampled in the cycle `pix_clk` is high.
- pix_clk, input, 1: one-cycle pixel write strobe.
- busy, output, 1: high when no strobe will be accepted.
- nreset, output, 1: LCD RESX.
- cmd_data, output, 1: LCD D/CX. 0 = command byte, 1 = data byte.
- write_edge, output, 1: LCD WRX. The panel latches `dout` on its rising edge.
- dout, output, 8: LCD D[7:0].

## Operation
- Reset values of all registered outputs: `nreset` = 0, `busy` = 1, `write_edge` = 1, `cmd_data` = 1, `dout` = 0x00. State = RST_LOW, counter = 0, pending flags cleared.
- States:
  - RST_LOW: holds `nreset` = 0 for RESET_LOW_CYCLES, then moves to RST_WAIT.
  - RST_WAIT: sets `nreset` = 1 and waits RESET_WAIT_CYCLES, then moves to INIT_A.
  - INIT_A: sends cmd 0x11, then moves to SLEEP_WAIT.
  - SLEEP_WAIT: waits SLEEP_WAIT_CYCLES, then moves to INIT_B.
  - INIT_B: sends cmd 0x3A, data 0x55, cmd 0x36, data 0x28, cmd 0x29, then moves to CURSOR.
  - CURSOR: sends cmd 0x2A, data 00 00 01 3F, cmd 0x2B, data 00 00 00 EF, cmd 0x2C (11 bytes), then moves to IDLE.
  - IDLE: `busy` = 0.
  - PIXEL: sends `pix_data[15:8]`, then `pix_data[7:0]`, both as data bytes, then returns to IDLE.
- The init byte list is a constant ROM of {dc, byte} entries, walked by an index counter.
- Byte engine, 2 cycles per byte:
  - Phase 0: drive `dout` and `cmd_data`, set `write_edge` = 0.
  - Phase 1: set `write_edge` = 1. `dout` and `cmd_data` hold.
- Delay counter is 21 bits. Every wait parameter must fit in it.
- In IDLE, `pix_clk` = 1: latch `pix_data` into the hold register and go to PIXEL.
- In IDLE, `reset_cursor` = 1: go to CURSOR.
- In IDLE, both strobes in the same cycle: CURSOR runs first. The pixel is latched and written immediately after CURSOR, before `busy` drops.
- `reset_cursor` while busy (in any state from INIT_A onward): set a pending flag. CURSOR runs right after the current sequence, and `busy` stays high through it. A pending flag raised during INIT is absorbed by INIT's own CURSOR pass.
- `pix_clk` while busy: ignored, data dropped. Upstream must obey `busy`.
- `resetn` low in any cycle: next state is the full reset values, including aborting a byte mid-phase. The full init sequence restarts.

## Timing
- All outputs are registered. No combinational path from input to output.
- `pix_clk` high in cycle t (IDLE):
  - t+1: `busy` = 1, `dout` = high byte, `cmd_data` = 1, `write_edge` = 0.
  - t+2: `write_edge` = 1.
  - t+3: `dout` = low byte, `write_edge` = 0.
  - t+4: `write_edge` = 1.
  - t+5: `busy` = 0, strobe accepted again.
- `reset_cursor` in cycle t (IDLE): 22 bus cycles, t+1 to t+22. `busy` = 0 at t+23.
- Init total: RESET_LOW + RESET_WAIT + 2 + SLEEP_WAIT + 10 + 22 cycles. `busy` falls the cycle after the last 0x2C phase 1.
- WRX low and high are each 62.5 ns, giving a 125 ns write cycle. This meets the ILI9341 write cycle minimum of 66 ns.

## Test plan
Bench parameters: RESET_LOW_CYCLES = 4, RESET_WAIT_CYCLES = 8, SLEEP_WAIT_CYCLES = 8.
- **Power-on:** hold `resetn` low for 3 cycles, then release.
  - `nreset` low for 4 cycles, then high.
  - Exactly 17 `write_edge` rising edges with (dc, byte) = (0,11) (0,3A) (1,55) (0,36) (1,28) (0,29) (0,2A) (1,00) (1,00) (1,01) (1,3F) (0,2B) (1,00) (1,00) (1,00) (1,EF) (0,2C).
  - Then `busy` = 0.
- **Pixel write:** in IDLE, one-cycle `pix_clk` with `pix_data` = 0xF81F.
  - Bytes F8 then 1F with `cmd_data` = 1, rising edges at t+2 and t+4.
  - `busy` high t+1..t+4, low at t+5.
- **Strobes while busy:** `pix_clk` with 0x1234 at t+2 of a pixel write.
  - No extra edges. 0x12 / 0x34 never appear on `dout`.
- **Simultaneous strobes:** `reset_cursor` and `pix_clk` (0xABCD) in the same IDLE cycle.
  - The 11-byte cursor sequence, then AB, CD.
  - `busy` stays high continuously for 26 cycles.
- **Cursor pending:** `reset_cursor` at t+3 of a pixel write.
  - Pixel completes, then the cursor sequence follows with no idle gap.
- **Reset mid-byte:** drop `resetn` for one cycle while `write_edge` = 0.
  - Next cycle: `nreset` = 0, `write_edge` = 1, `busy` = 1, `dout` = 00.
  - The full 17-byte init repeats.
